pushbutton_processor_multi: RTL and testbench
=============================================

Name: pushbutton_processor_multi

Overview:
Parametrised successor to the single-button processor. It handles N independent pushbutton channels on the 1 kHz tick clock, one tick per ms. Each channel synchronises and debounces its raw button input, then classifies each press as short or long. While a long press is held, the channel emits auto-repeat pulses. The one-cycle event outputs drive the scoreboard counter logic (short = count up, long/repeat = count down).

Parameters:
- N_CH, 4, number of button channels (1..16).
- DEBOUNCE_MS, 20, consecutive stable cycles needed to accept a level change (>=2).
- LONG_MS, 2000, held cycles after debounced press before the long-press event (> DEBOUNCE_MS).
- REPEAT_MS, 250, interval between repeat pulses after a long press; 0 disables repeat.

Ports:
- clk_1khz  in  1  1 kHz system clock.
- rst_i  in  1  synchronous, active-low reset.
- pushbutton_i  in  N_CH  raw asynchronous button levels, 1 = pressed.
- pressed_o  out  N_CH  debounced button level per channel.
- short_press_o  out  N_CH  one-cycle pulse on release of a press shorter than LONG_MS.
- long_press_o  out  N_CH  one-cycle pulse when a press reaches LONG_MS.
- repeat_o  out  N_CH  one-cycle pulse every REPEAT_MS while held after a long press.

Behaviour:
- Reset (rst_i==0 at a clk_1khz edge):
  - All synchroniser flops, debounce counters, hold counters and repeat counters go to 0.
  - All FSMs go to IDLE.
  - All outputs are 0.
- Reset mid-press: any press in progress is discarded, with no pulses. A button still held after reset release is re-debounced and treated as a new press.
- Synchroniser: 2-flop synchroniser per channel. Every output is registered.
- Debounce, per channel:
  - The counter clears whenever the synced level equals pressed_o.
  - Otherwise the counter increments. When it reaches DEBOUNCE_MS-1, pressed_o toggles and the counter clears.
  - Net latency from a stable input edge to the pressed_o edge is 2+DEBOUNCE_MS cycles.
  - Glitches shorter than DEBOUNCE_MS cycles never change pressed_o.
- Classifier FSM, per channel, with states IDLE, PRESSED, HELD:
  - IDLE: on the first cycle pressed_o==1, go to PRESSED with hold_cnt=1.
  - PRESSED, pressed_o==0: assert short_press_o for one cycle, coincident with the first low cycle of pressed_o, and go to IDLE.
  - PRESSED, hold_cnt==LONG_MS-1 while still pressed: assert long_press_o for one cycle, exactly LONG_MS cycles after the pressed_o rising edge. Go to HELD with rep_cnt=0.
  - PRESSED otherwise: hold_cnt increments.
  - HELD, pressed_o==0: go to IDLE with no short_press_o. Release after a long press produces no event.
  - HELD with REPEAT_MS>0: rep_cnt increments. When it reaches REPEAT_MS-1, assert repeat_o for one cycle and clear rep_cnt. The first repeat comes REPEAT_MS cycles after long_press_o.
  - HELD with REPEAT_MS==0: repeat_o stays 0.
- Boundaries and invariants:
  - A release in the same cycle hold_cnt would reach LONG_MS-1 counts as short; release takes priority.
  - Counters saturate and never wrap.
  - Widths: hold_cnt is $clog2(LONG_MS) bits, deb_cnt is $clog2(DEBOUNCE_MS) bits, rep_cnt is $clog2(REPEAT_MS+1) bits.
  - Channels are fully independent: simultaneous events on several channels assert their bits in the same cycle.
  - At most one of short/long/repeat is high per channel per cycle.

Decomposition:
- Shared package pb_pkg holds:
  - the FSM state enum (IDLE=2'd0, PRESSED=2'd1, HELD=2'd2);
  - default timing constants DEBOUNCE_MS_DEF, LONG_MS_DEF, REPEAT_MS_DEF.
- One natural sub-module: pb_channel, containing the synchroniser, debouncer and classifier for one button. The top level instantiates N_CH copies with a generate loop and only concatenates the per-channel bits.

Test Plan:
1. Reset (rst_i=0 for 5 cycles), then ch0 bounces (1/0 at 1–2 ms intervals for 8 ms), holds 30 ms, then releases. Expect:
   - one pressed_o[0] high period;
   - exactly one short_press_o[0] pulse on its falling edge;
   - long_press_o and repeat_o stay 0.
2. Ch1 held for a 10 ms glitch (shorter than DEBOUNCE_MS=20). Expect pressed_o[1] and all event outputs to stay 0.
3. Ch2 held 2100 ms, then released with bounce. Expect:
   - long_press_o[2] exactly 2000 cycles after pressed_o[2] rises;
   - no short_press_o[2] on release.
4. Ch3 held 2600 ms after debounce. Expect:
   - long_press_o at 2000 ms;
   - repeat_o pulses at 2250 ms and 2500 ms (two pulses).
   - Rerun with REPEAT_MS=0: no repeat pulses.
5. Ch0 and ch1 pressed in the same cycle, 50 ms each. Expect short_press_o==4'b0011 in a single cycle.
6. Ch2 held, with rst_i=0 for 3 cycles at 1500 ms, button still held. Expect:
   - all outputs 0 during reset;
   - pressed_o[2] re-asserts 22 cycles after reset release;
   - long_press_o 2000 cycles after that, with no earlier event.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared classifier state encoding and default timing for the pushbutton processor.
// All timing values are in 1 kHz ticks (ms).
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } pb_state_e;

  localparam int DEBOUNCE_MS_DEF = 20;
  localparam int LONG_MS_DEF     = 2000;
  localparam int REPEAT_MS_DEF   = 250;

endpackage

// File: rtl/pb_channel.sv
// One pushbutton channel: 2-flop synchroniser, debouncer and short/long/repeat classifier.
//
//   state   | meaning
//   IDLE    | button released, waiting for a debounced press
//   PRESSED | press accepted, timing toward the long-press threshold
//   HELD    | long press reported, emitting auto-repeat pulses
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int LONG_MS     = LONG_MS_DEF,
  parameter int REPEAT_MS   = REPEAT_MS_DEF
) (
  input  logic clk_1khz,
  input  logic rst_i,
  input  logic pushbutton_i,
  output logic pressed_o,
  output logic short_press_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int DEB_W  = $clog2(DEBOUNCE_MS);
  localparam int HOLD_W = $clog2(LONG_MS);
  // A zero repeat interval still needs a legal one-bit counter.
  localparam int REP_W  = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = (REPEAT_MS > 0) ? REP_W'(REPEAT_MS - 1) : '0;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_pressed;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic              w_deb_done;
  logic              w_release;

  pb_state_e         r_state;
  pb_state_e         w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [REP_W-1:0]  w_rep_nxt;
  logic              r_short;
  logic              r_long;
  logic              r_repeat;
  logic              w_short_nxt;
  logic              w_long_nxt;
  logic              w_repeat_nxt;

  assign w_deb_done = (r_sync2 != r_pressed) && (r_deb_cnt == DEB_LAST);
  // Release is seen on the same edge pressed_o falls so short_press_o lines up with it.
  assign w_release  = w_deb_done && r_pressed;

  always_ff @(posedge clk_1khz) begin
    if (!rst_i) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_pressed <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= pushbutton_i;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_pressed) begin
        r_deb_cnt <= '0;
      end else if (w_deb_done) begin
        r_pressed <= ~r_pressed;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end
  end

  // Counters only advance below their terminal value, so they can never wrap.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_rep_nxt    = r_rep_cnt;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pressed && !w_release) begin
          w_state_nxt = PRESSED;
          w_hold_nxt  = HOLD_W'(1);
        end
      end
      PRESSED: begin
        if (w_release) begin
          w_short_nxt = 1'b1;
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = HELD;
          w_rep_nxt   = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      HELD: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end else if (REPEAT_MS > 0) begin
          if (r_rep_cnt == REP_LAST) begin
            w_repeat_nxt = 1'b1;
            w_rep_nxt    = '0;
          end else begin
            w_rep_nxt = r_rep_cnt + REP_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
        w_rep_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_short    <= w_short_nxt;
      r_long     <= w_long_nxt;
      r_repeat   <= w_repeat_nxt;
    end
  end

  assign pressed_o     = r_pressed;
  assign short_press_o = r_short;
  assign long_press_o  = r_long;
  assign repeat_o      = r_repeat;

endmodule

// File: rtl/pushbutton_processor_multi.sv
// N independent pushbutton channels on the 1 kHz tick clock.
// Each output bus bit belongs to the channel with the same index.
module pushbutton_processor_multi
  import pb_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int LONG_MS     = LONG_MS_DEF,
  parameter int REPEAT_MS   = REPEAT_MS_DEF
) (
  input  logic            clk_1khz,
  input  logic            rst_i,
  input  logic [N_CH-1:0] pushbutton_i,
  output logic [N_CH-1:0] pressed_o,
  output logic [N_CH-1:0] short_press_o,
  output logic [N_CH-1:0] long_press_o,
  output logic [N_CH-1:0] repeat_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_ch (
      .clk_1khz      (clk_1khz),
      .rst_i         (rst_i),
      .pushbutton_i  (pushbutton_i[g]),
      .pressed_o     (pressed_o[g]),
      .short_press_o (short_press_o[g]),
      .long_press_o  (long_press_o[g]),
      .repeat_o      (repeat_o[g])
    );
  end

endmodule

// File: tb/tb_pushbutton_processor_multi.sv
// Bench for pushbutton_processor_multi: two instances (repeat 250 ms and repeat disabled)
// share one stimulus and are compared every tick against a timestamp-based reference model.
module tb_pushbutton_processor_multi;

  localparam int DEB  = 20;
  localparam int LONG = 2000;
  localparam int REP  = 250;

  logic       clk_1khz = 1'b0;
  logic       rst_i    = 1'b0;
  logic [3:0] pb       = 4'b0;
  logic [3:0] pa, sa, la, ra;
  logic [3:0] pbb, sb, lb, rb;

  always #5 clk_1khz = ~clk_1khz;

  pushbutton_processor_multi #(.N_CH(4), .DEBOUNCE_MS(DEB), .LONG_MS(LONG), .REPEAT_MS(REP)) dut_a (
    .clk_1khz(clk_1khz), .rst_i(rst_i), .pushbutton_i(pb),
    .pressed_o(pa), .short_press_o(sa), .long_press_o(la), .repeat_o(ra));

  pushbutton_processor_multi #(.N_CH(4), .DEBOUNCE_MS(DEB), .LONG_MS(LONG), .REPEAT_MS(0)) dut_b (
    .clk_1khz(clk_1khz), .rst_i(rst_i), .pushbutton_i(pb),
    .pressed_o(pbb), .short_press_o(sb), .long_press_o(lb), .repeat_o(rb));

  int nvec = 0;
  int nerr = 0;
  int edge_n = 0;

  // reference model state: raw history, debounced level, mismatch run, press start time
  bit d1[4], d2[4], mp[4], act[4];
  int run[4], start[4];
  logic [3:0] e_p, e_s, e_l, e_ra, e_rb;

  // observed-event tallies for the directed scenarios
  int c_rise[4], c_s[4], c_l[4], c_r[4], c_rb[4], t_rise[4], t_long[4], t_rep[4];
  int n0011;
  logic [3:0] prev_pa = 4'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    edge_n++;
    e_s = '0; e_l = '0; e_ra = '0; e_rb = '0;
    for (int c = 0; c < 4; c++) begin
      bit dl;
      bit old;
      int age;
      if (!rst_i) begin
        d1[c] = 0; d2[c] = 0; mp[c] = 0; act[c] = 0; run[c] = 0;
      end else begin
        dl = d2[c];
        d2[c] = d1[c];
        d1[c] = pb[c];
        old = mp[c];
        if (dl != mp[c]) begin
          run[c]++;
          if (run[c] == DEB) begin
            mp[c] = ~mp[c];
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
        if (!old && mp[c]) begin
          act[c] = 1;
          start[c] = edge_n;
        end
        if (old && !mp[c]) begin
          if (act[c] && (edge_n - start[c] <= LONG)) e_s[c] = 1'b1;
          act[c] = 0;
        end
        if (act[c] && mp[c]) begin
          age = edge_n - start[c];
          if (age == LONG) e_l[c] = 1'b1;
          if (age > LONG && ((age - LONG) % REP) == 0) e_ra[c] = 1'b1;
        end
      end
      e_p[c] = mp[c];
    end
  endtask

  task automatic step();
    @(posedge clk_1khz);
    #1;
    model_edge();
    chk("pressed_a", pa,  e_p);
    chk("short_a",   sa,  e_s);
    chk("long_a",    la,  e_l);
    chk("repeat_a",  ra,  e_ra);
    chk("pressed_b", pbb, e_p);
    chk("short_b",   sb,  e_s);
    chk("long_b",    lb,  e_l);
    chk("repeat_b",  rb,  e_rb);
    for (int c = 0; c < 4; c++) begin
      if (pa[c] && !prev_pa[c]) begin c_rise[c]++; t_rise[c] = edge_n; end
      if (sa[c]) c_s[c]++;
      if (la[c]) begin c_l[c]++; t_long[c] = edge_n; end
      if (ra[c]) begin if (c_r[c] == 0) t_rep[c] = edge_n; c_r[c]++; end
      if (rb[c]) c_rb[c]++;
    end
    if (sa == 4'b0011) n0011++;
    prev_pa = pa;
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < 4; c++) begin
      c_rise[c] = 0; c_s[c] = 0; c_l[c] = 0; c_r[c] = 0; c_rb[c] = 0;
      t_rise[c] = 0; t_long[c] = 0; t_rep[c] = 0;
    end
    n0011 = 0;
  endtask

  initial begin
    int n, tt, k_rise, k_long;
    int rem[4];

    // reset
    rst_i = 1'b0;
    repeat (5) step();
    chk("reset_pressed", pa, 0);
    rst_i = 1'b1;

    // ch0 bouncy short press
    clr_cnt();
    tt = 0;
    while (tt < 8) begin
      pb[0] = ~pb[0];
      n = $urandom_range(2, 1);
      repeat (n) step();
      tt += n;
    end
    pb[0] = 1'b1;
    repeat (30) step();
    pb[0] = 1'b0;
    repeat (40) step();
    chk("t1_rise_cnt", c_rise[0], 1);
    chk("t1_short_cnt", c_s[0], 1);
    chk("t1_long_cnt", c_l[0] + c_r[0], 0);

    // ch1 glitch shorter than the debounce window
    clr_cnt();
    pb[1] = 1'b1;
    repeat (10) step();
    pb[1] = 1'b0;
    repeat (40) step();
    chk("t2_rise_cnt", c_rise[1], 0);
    chk("t2_event_cnt", c_s[1] + c_l[1] + c_r[1], 0);

    // ch2 long press, bouncy release
    clr_cnt();
    pb[2] = 1'b1;
    repeat (2100) step();
    tt = 0;
    while (tt < 6) begin
      pb[2] = ~pb[2];
      n = $urandom_range(2, 1);
      repeat (n) step();
      tt += n;
    end
    pb[2] = 1'b0;
    repeat (40) step();
    chk("t3_long_cnt", c_l[2], 1);
    chk("t3_long_delay", t_long[2] - t_rise[2], LONG);
    chk("t3_short_cnt", c_s[2], 0);

    // ch3 long press with auto-repeat
    clr_cnt();
    pb[3] = 1'b1;
    repeat (22 + 2600) step();
    pb[3] = 1'b0;
    repeat (40) step();
    chk("t4_long_cnt", c_l[3], 1);
    chk("t4_repeat_cnt", c_r[3], 2);
    chk("t4_first_repeat", t_rep[3] - t_long[3], REP);
    chk("t4_repeat_off_cnt", c_rb[3], 0);

    // ch0 and ch1 simultaneously
    clr_cnt();
    pb[1:0] = 2'b11;
    repeat (50) step();
    pb[1:0] = 2'b00;
    repeat (40) step();
    chk("t5_joint_short", n0011, 1);

    // ch2 held across a reset
    clr_cnt();
    pb[2] = 1'b1;
    repeat (22 + 1500) step();
    rst_i = 1'b0;
    repeat (3) begin
      step();
      chk("t6_rst_pressed", pa, 0);
      chk("t6_rst_events", {sa, la, ra}, 0);
    end
    rst_i = 1'b1;
    clr_cnt();
    k_rise = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (pa[2]) begin k_rise = k; break; end
    end
    chk("t6_redebounce", k_rise, 22);
    k_long = -1;
    for (int k = 1; k <= 2100; k++) begin
      step();
      if (la[2]) begin k_long = k; break; end
    end
    chk("t6_long_delay", k_long, LONG);
    chk("t6_early_events", c_s[2] + c_r[2], 0);
    pb[2] = 1'b0;
    repeat (40) step();

    // release exactly at the long threshold counts as short
    clr_cnt();
    pb[1] = 1'b1;
    repeat (LONG) step();
    pb[1] = 1'b0;
    repeat (40) step();
    chk("t7_edge_short", c_s[1], 1);
    chk("t7_edge_long", c_l[1], 0);
    clr_cnt();
    pb[1] = 1'b1;
    repeat (LONG + 1) step();
    pb[1] = 1'b0;
    repeat (40) step();
    chk("t7_over_short", c_s[1], 0);
    chk("t7_over_long", c_l[1], 1);

    // random independent activity on all channels
    for (int c = 0; c < 4; c++) rem[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          pb[c] = ~pb[c];
          rem[c] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2400, 60))
                                                : int'($urandom_range(40, 1));
        end
        rem[c]--;
      end
      step();
    end
    pb = 4'b0;
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
